// File: rtl/tdm_demux16.sv
// tdm_demux16: serial TDM receiver steering 16 slots into a registered parallel frame.
// An internal slot counter places each valid bit; a completed frame lands in Q with a one-cycle q_valid.
module tdm_demux16 #(
  parameter int BIT_ORDER  = 0,
  parameter int CONTINUOUS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  input  logic        sof,
  output logic [15:0] Q,
  output logic        q_valid,
  output logic [3:0]  slot,
  output logic        busy,
  output logic        frame_err
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state;
  logic [15:0] frame_buf;
  logic [15:0] fill;
  logic [15:0] first;
  function automatic logic [3:0] pos(input logic [3:0] k);
    return BIT_ORDER != 0 ? ~k : k;
  endfunction
  // fill: buffer with the current bit merged in; first: a fresh frame holding only slot 0
  always_comb begin
    fill = frame_buf;
    fill[pos(slot)] = din;
    first = '0;
    first[pos(4'd0)] = din;
  end
  assign busy = state == RECV;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      frame_buf <= '0;
      slot      <= '0;
      Q         <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      if (din_valid) begin
        if (state == IDLE) begin
          if (sof || CONTINUOUS != 0) begin
            frame_buf <= first;
            slot      <= 4'd1;
            state     <= RECV;
          end
        end else if (sof && slot != 4'd0) begin
          frame_err <= 1'b1;
          frame_buf <= first;
          slot      <= 4'd1;
        end else if (slot == 4'd15) begin
          Q         <= fill;
          q_valid   <= 1'b1;
          frame_buf <= '0;
          slot      <= 4'd0;
          state     <= CONTINUOUS != 0 ? RECV : IDLE;
        end else begin
          frame_buf <= fill;
          slot      <= slot + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16: drives all four BIT_ORDER/CONTINUOUS builds with one stream and scores them
// against a bit-list reference model through an event scoreboard.
module tb_tdm_demux16;
  logic clk = 1'b0;
  logic rst, din, din_valid, sof;
  logic [15:0] q_o [4];
  logic        qv_o [4];
  logic [3:0]  slot_o [4];
  logic        busy_o [4];
  logic        err_o [4];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : inst
    tdm_demux16 #(.BIT_ORDER(g % 2), .CONTINUOUS(g / 2)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
      .Q(q_o[g]), .q_valid(qv_o[g]), .slot(slot_o[g]), .busy(busy_o[g]), .frame_err(err_o[g])
    );
  end
  typedef struct {int inst; int cyc; bit err; logic [15:0] q;} ev_t;
  ev_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit done = 0;
  bit final_chk = 0;
  int n [4];
  bit inf [4];
  logic [15:0] recv [4];
  logic [15:0] last_q [4];
  // Reference: collect bits in arrival order, then map to positions once 16 have arrived.
  task automatic model_step();
    logic [15:0] w;
    int bo, co;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      bo = i % 2;
      co = i / 2;
      if (rst) begin
        n[i] = 0; inf[i] = 0; last_q[i] = 0; recv[i] = 0;
      end else if (din_valid) begin
        if (sof) begin
          if (inf[i] && n[i] != 0) sb.push_back('{i, cyc, 1'b1, 16'h0});
          recv[i][0] = din; n[i] = 1; inf[i] = 1;
        end else if (inf[i] || co != 0) begin
          recv[i][n[i]] = din; n[i]++; inf[i] = 1;
        end
        if (n[i] == 16) begin
          w = 0;
          for (int k = 0; k < 16; k++) w[bo != 0 ? 15 - k : k] = recv[i][k];
          last_q[i] = w;
          sb.push_back('{i, cyc, 1'b0, w});
          n[i] = 0;
          inf[i] = co != 0;
        end
      end
    end
  endtask
  task automatic drive(input logic d, input logic v, input logic s, input logic r);
    din = d; din_valid = v; sof = s; rst = r;
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic send(input logic [15:0] w, input bit with_sof, input bit gaps);
    for (int k = 0; k < 16; k++) begin
      drive(w[k], 1'b1, with_sof && k == 0, 1'b0);
      if (gaps && (k == 4 || k == 11))
        for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask
  task automatic check(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cyc%0d: got %h want %h", nm, i, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 4; i++) begin
        bit hv, he;
        logic [15:0] hq;
        hv = 0; he = 0; hq = 0;
        for (int j = sb.size() - 1; j >= 0; j--)
          if (sb[j].inst == i && sb[j].cyc == cyc) begin
            if (sb[j].err) he = 1;
            else begin hv = 1; hq = sb[j].q; end
            sb.delete(j);
          end
        check("q_valid", i, 16'(qv_o[i]), 16'(hv));
        check("frame_err", i, 16'(err_o[i]), 16'(he));
        if (hv) check("Q_frame", i, q_o[i], hq);
        check("Q_hold", i, q_o[i], last_q[i]);
        check("slot", i, 16'(slot_o[i]), 16'(n[i]));
        check("busy", i, 16'(busy_o[i]), 16'(inf[i]));
      end
      if (done && !final_chk) begin
        check("sb_empty", -1, 16'(sb.size()), 16'd0);
        final_chk = 1;
      end
    end
  end
  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    send(16'hA5C3, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    send(16'hA5C3, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, k == 0, 1'b0);
    send(16'h1234, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) drive(1'b1, 1'b1, k == 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0001, 1'b1, 1'b0);
    send(16'h8000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0001, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 1500; c++)
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 299) == 0);
    for (int c = 0; c < 64; c++) drive($urandom_range(0, 1) == 1, 1'b1, c == 0, 1'b0);
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    done = 1;
    for (int j = 0; j < 3; j++) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
